dma_s2mm_writer: RTL and testbench

Stream-to-memory DMA engine for the Zynq ACP port. It is the write-direction counterpart of the existing memory-to-stream read DMA. It accepts a 64-bit valid/ready stream of accelerator results, buffers it in an internal FIFO, and writes it to DDR as AXI3 INCR bursts of up to 16 beats. One burst is outstanding at a time, and each burst retires on its write response. It sits between the accelerator output stream and the ACP master port of the wrapper.

---
 rtl/dma_s2mm_writer_if.sv | 50 +++++
 rtl/dma_s2mm_writer.sv | 179 +++++++++++++++++
 tb/tb_dma_s2mm_writer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_s2mm_writer_if.sv
// Accelerator result stream plus the AXI3 ACP write channels of the S2MM DMA.
interface dma_s2mm_writer_if;
    logic [63:0] s2mm_data;
    logic        s2mm_valid;
    logic        s2mm_ready;

    logic [2:0]  m_axi_acp_awid;
    logic [31:0] m_axi_acp_awaddr;
    logic [3:0]  m_axi_acp_awlen;
    logic [2:0]  m_axi_acp_awsize;
    logic [1:0]  m_axi_acp_awburst;
    logic [1:0]  m_axi_acp_awlock;
    logic [3:0]  m_axi_acp_awcache;
    logic [2:0]  m_axi_acp_awprot;
    logic [3:0]  m_axi_acp_awqos;
    logic [4:0]  m_axi_acp_awuser;
    logic        m_axi_acp_awvalid;
    logic        m_axi_acp_awready;

    logic [2:0]  m_axi_acp_wid;
    logic [63:0] m_axi_acp_wdata;
    logic [7:0]  m_axi_acp_wstrb;
    logic        m_axi_acp_wlast;
    logic        m_axi_acp_wvalid;
    logic        m_axi_acp_wready;

    logic [1:0]  m_axi_acp_bresp;
    logic        m_axi_acp_bvalid;
    logic        m_axi_acp_bready;

    modport master (
        input  s2mm_data, s2mm_valid, m_axi_acp_awready, m_axi_acp_wready,
               m_axi_acp_bresp, m_axi_acp_bvalid,
        output s2mm_ready, m_axi_acp_awid, m_axi_acp_awaddr, m_axi_acp_awlen,
               m_axi_acp_awsize, m_axi_acp_awburst, m_axi_acp_awlock, m_axi_acp_awcache,
               m_axi_acp_awprot, m_axi_acp_awqos, m_axi_acp_awuser, m_axi_acp_awvalid,
               m_axi_acp_wid, m_axi_acp_wdata, m_axi_acp_wstrb, m_axi_acp_wlast,
               m_axi_acp_wvalid, m_axi_acp_bready
    );

    modport slave (
        output s2mm_data, s2mm_valid, m_axi_acp_awready, m_axi_acp_wready,
               m_axi_acp_bresp, m_axi_acp_bvalid,
        input  s2mm_ready, m_axi_acp_awid, m_axi_acp_awaddr, m_axi_acp_awlen,
               m_axi_acp_awsize, m_axi_acp_awburst, m_axi_acp_awlock, m_axi_acp_awcache,
               m_axi_acp_awprot, m_axi_acp_awqos, m_axi_acp_awuser, m_axi_acp_awvalid,
               m_axi_acp_wid, m_axi_acp_wdata, m_axi_acp_wstrb, m_axi_acp_wlast,
               m_axi_acp_wvalid, m_axi_acp_bready
    );
endinterface

// File: rtl/dma_s2mm_writer.sv
// Stream-to-memory DMA: buffers a 64-bit stream in a FIFO and writes it to DDR
// as AXI3 INCR bursts, one burst outstanding, each retired on its write response.
module dma_s2mm_writer #(
    parameter int unsigned DATA_SIZE     = 1280*720*3/8,
    parameter int unsigned DATA_SIZE_LOG = 19,
    parameter int unsigned BURST_SIZE    = 16,
    parameter int unsigned FIFO_DEPTH    = 32
) (
    input  logic              m_axi_acp_aclk,
    input  logic              axi_reset,
    input  logic              start,
    input  logic [31:0]       dst_addr,
    output logic              busy,
    output logic              done,
    output logic              error,
    dma_s2mm_writer_if.master bus
);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned LEN_W   = $clog2(BURST_SIZE) + 1;
    localparam int unsigned ALIGN_W = $clog2(BURST_SIZE * 8);
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << ALIGN_W) - 32'd1);
    localparam logic [DATA_SIZE_LOG-1:0] TOTAL = DATA_SIZE_LOG'(DATA_SIZE);
    localparam logic [DATA_SIZE_LOG-1:0] BURST = DATA_SIZE_LOG'(BURST_SIZE);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, FILL, ADDR, DATA, RESP, DONE} state_t;

    state_t                   state, state_next;
    logic [63:0]              mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_full, push, pop;
    logic [DATA_SIZE_LOG-1:0] in_count, remaining;
    logic [31:0]              addr, awaddr;
    logic [3:0]               awlen, beat;
    logic [LEN_W-1:0]         len;
    logic                     awvalid, wlast, bready;
    logic                     awvalid_next, wlast_next, bready_next, busy_next, done_next;

    assign fifo_full       = (fifo_count == FULL_CNT);
    assign bus.s2mm_ready  = busy && !fifo_full && (in_count < TOTAL);
    assign push            = bus.s2mm_valid && bus.s2mm_ready;
    assign bus.m_axi_acp_wvalid = (state == DATA);
    assign bus.m_axi_acp_wdata  = mem[rd_ptr];
    assign pop             = bus.m_axi_acp_wvalid && bus.m_axi_acp_wready;
    assign len             = (remaining >= BURST) ? LEN_W'(BURST_SIZE) : LEN_W'(remaining);

    assign bus.m_axi_acp_awid    = 3'b100;
    assign bus.m_axi_acp_awaddr  = awaddr;
    assign bus.m_axi_acp_awlen   = awlen;
    assign bus.m_axi_acp_awsize  = 3'b011;
    assign bus.m_axi_acp_awburst = 2'b01;
    assign bus.m_axi_acp_awlock  = 2'b00;
    assign bus.m_axi_acp_awcache = 4'b0001;
    assign bus.m_axi_acp_awprot  = 3'b010;
    assign bus.m_axi_acp_awqos   = '0;
    assign bus.m_axi_acp_awuser  = '0;
    assign bus.m_axi_acp_awvalid = awvalid;
    assign bus.m_axi_acp_wid     = 3'b100;
    assign bus.m_axi_acp_wstrb   = '1;
    assign bus.m_axi_acp_wlast   = wlast;
    assign bus.m_axi_acp_bready  = bready;

    // Storage carries no reset; flushing only needs the pointers and count cleared.
    always_ff @(posedge m_axi_acp_aclk) begin
        if (push) mem[wr_ptr] <= bus.s2mm_data;
    end

    always_ff @(posedge m_axi_acp_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge m_axi_acp_aclk or posedge axi_reset) begin
        if (axi_reset) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next   = state;
        awvalid_next = awvalid;
        wlast_next   = wlast;
        bready_next  = bready;
        busy_next    = busy;
        done_next    = 1'b0;
        unique case (state)
            IDLE: if (start) begin
                state_next = FILL;
                busy_next  = 1'b1;
            end
            FILL: if (fifo_count >= CNT_W'(len)) begin
                state_next   = ADDR;
                awvalid_next = 1'b1;
            end
            ADDR: if (bus.m_axi_acp_awready) begin
                state_next   = DATA;
                awvalid_next = 1'b0;
                wlast_next   = (awlen == 4'd0);
            end
            DATA: if (pop && wlast) begin
                state_next  = RESP;
                wlast_next  = 1'b0;
                bready_next = 1'b1;
            end else if (pop) begin
                wlast_next  = (beat + 4'd1 == awlen);
            end
            RESP: if (bus.m_axi_acp_bvalid) begin
                bready_next = 1'b0;
                if (remaining == DATA_SIZE_LOG'(len)) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    state_next = FILL;
                end
            end
            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_acp_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            awvalid   <= 1'b0;
            wlast     <= 1'b0;
            bready    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            addr      <= '0;
            awaddr    <= '0;
            awlen     <= '0;
            beat      <= '0;
            remaining <= '0;
            in_count  <= '0;
        end else begin
            awvalid <= awvalid_next;
            wlast   <= wlast_next;
            bready  <= bready_next;
            busy    <= busy_next;
            done    <= done_next;
            if (push) in_count <= in_count + DATA_SIZE_LOG'(1);
            case (state)
                IDLE: if (start) begin
                    addr      <= dst_addr & ALIGN_MASK;
                    remaining <= TOTAL;
                    in_count  <= '0;
                    error     <= 1'b0;
                end
                FILL: if (state_next == ADDR) begin
                    awaddr <= addr;
                    awlen  <= 4'(len - LEN_W'(1));
                end
                ADDR: beat <= '0;
                DATA: if (pop) beat <= beat + 4'd1;
                RESP: if (bus.m_axi_acp_bvalid) begin
                    error     <= error | (bus.m_axi_acp_bresp != 2'b00);
                    addr      <= addr + 32'({len, 3'b000});
                    remaining <= remaining - DATA_SIZE_LOG'(len);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_s2mm_writer.sv
// Scoreboard bench for dma_s2mm_writer: three instances (32, 20 and 64 beats)
// share the stimulus; only the selected one is started and observed.
`timescale 1ns/1ps
module tb_dma_s2mm_writer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0]  sel = 2'd0;
    logic        start = 1'b0;
    logic [31:0] dst = '0;
    logic [63:0] s_data = '0;
    logic        s_valid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [1:0]  bresp = 2'b00;

    logic [2:0]  v_awvalid, v_wvalid, v_wlast, v_bready, v_ready, v_busy, v_done, v_error;
    logic [31:0] v_awaddr [3];
    logic [3:0]  v_awlen [3];
    logic [63:0] v_wdata [3];

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int unsigned DS = (g == 0) ? 32 : (g == 1) ? 20 : 64;
        dma_s2mm_writer_if bus ();
        assign bus.s2mm_data         = s_data;
        assign bus.s2mm_valid        = s_valid;
        assign bus.m_axi_acp_awready = awready;
        assign bus.m_axi_acp_wready  = wready;
        assign bus.m_axi_acp_bresp   = bresp;
        assign bus.m_axi_acp_bvalid  = bvalid;
        dma_s2mm_writer #(.DATA_SIZE(DS), .DATA_SIZE_LOG(7), .BURST_SIZE(16), .FIFO_DEPTH(32)) dut (
            .m_axi_acp_aclk(clk), .axi_reset(rst), .start(start && (sel == g)), .dst_addr(dst),
            .busy(v_busy[g]), .done(v_done[g]), .error(v_error[g]), .bus(bus));
        assign v_awvalid[g] = bus.m_axi_acp_awvalid;
        assign v_awaddr[g]  = bus.m_axi_acp_awaddr;
        assign v_awlen[g]   = bus.m_axi_acp_awlen;
        assign v_wvalid[g]  = bus.m_axi_acp_wvalid;
        assign v_wdata[g]   = bus.m_axi_acp_wdata;
        assign v_wlast[g]   = bus.m_axi_acp_wlast;
        assign v_bready[g]  = bus.m_axi_acp_bready;
        assign v_ready[g]   = bus.s2mm_ready;
    end

    logic        o_awvalid, o_wvalid, o_wlast, o_bready, o_ready, o_busy, o_done, o_error;
    logic [31:0] o_awaddr;
    logic [3:0]  o_awlen;
    logic [63:0] o_wdata;
    assign o_awvalid = v_awvalid[sel];
    assign o_awaddr  = v_awaddr[sel];
    assign o_awlen   = v_awlen[sel];
    assign o_wvalid  = v_wvalid[sel];
    assign o_wdata   = v_wdata[sel];
    assign o_wlast   = v_wlast[sel];
    assign o_bready  = v_bready[sel];
    assign o_ready   = v_ready[sel];
    assign o_busy    = v_busy[sel];
    assign o_done    = v_done[sel];
    assign o_error   = v_error[sel];

    task automatic idle_inputs();
        s_valid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; start = 1'b0;
    endtask

    // One transfer: AXI slave + stream source in a single per-negedge loop.
    task automatic run_xfer(input logic [1:0] which, input logic [31:0] addr, input int n,
                            input int aw_delay, input bit wtoggle, input int stop_at,
                            input int pause, input logic [1:0] resp0, input logic exp_err,
                            input string tag);
        logic [31:0] exp_addr[$];
        logic [3:0]  exp_len[$];
        logic [63:0] exp_w[$];
        logic [31:0] base, hold_addr, ea;
        logic [3:0]  hold_len, el;
        logic [63:0] cur, ew;
        int rem, blen, sent, written, bursts, aw_wait, paused, beat, cur_len, cyc;
        bit pend_b, aw_seen, aw_due, in_fill, wtog, fin;
        sent = 0; written = 0; bursts = 0; aw_wait = 0; paused = 0; beat = 0; cur_len = 0; cyc = 0;
        pend_b = 0; aw_seen = 0; aw_due = 0; in_fill = 1; wtog = 0; fin = 0;
        hold_addr = '0; hold_len = '0;
        cur = {$urandom, $urandom};
        base = addr & 32'hFFFF_FF80;
        rem = n;
        while (rem > 0) begin
            blen = (rem > 16) ? 16 : rem;
            exp_addr.push_back(base);
            exp_len.push_back(4'(blen - 1));
            base = base + 32'(blen * 8);
            rem = rem - blen;
        end
        idle_inputs();
        sel = which;
        @(negedge clk); dst = addr; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_vec++;
        if ({o_busy, o_error} !== 2'b10) begin
            n_err++; $display("FAIL %s start: busy/error=%b, required 10", tag, {o_busy, o_error});
        end
        while (!fin && cyc < 3000) begin
            awready = 1'b0;
            if (aw_due) begin
                n_vec++;
                if (o_awvalid !== 1'b1) begin
                    n_err++; $display("FAIL %s aw_latency: awvalid=%b, required 1", tag, o_awvalid);
                end
                aw_due = 0;
            end
            if (aw_seen) begin
                n_vec++;
                if ({o_awvalid, o_awaddr, o_awlen} !== {1'b1, hold_addr, hold_len}) begin
                    n_err++;
                    $display("FAIL %s aw_hold: valid=%b addr=%h len=%0d, required 1 %h %0d",
                             tag, o_awvalid, o_awaddr, o_awlen, hold_addr, hold_len);
                end
            end else if (o_awvalid) begin
                aw_seen = 1; hold_addr = o_awaddr; hold_len = o_awlen; aw_wait = 0; in_fill = 0;
                n_vec++;
                if (exp_len.size() == 0 || sent - written < int'(exp_len[0]) + 1) begin
                    n_err++; $display("FAIL %s aw_early: buffered=%0d when awvalid rose", tag, sent - written);
                end
            end else if (in_fill && exp_len.size() > 0 && sent - written >= int'(exp_len[0]) + 1) begin
                aw_due = 1;
            end
            if (o_awvalid) begin
                if (aw_wait >= aw_delay) begin
                    awready = 1'b1; aw_seen = 0; beat = 0;
                    n_vec++;
                    if (exp_addr.size() == 0) begin
                        n_err++; $display("FAIL %s aw_extra: addr=%h, required no burst", tag, o_awaddr);
                    end else begin
                        ea = exp_addr.pop_front(); el = exp_len.pop_front(); cur_len = int'(el);
                        if (o_awaddr !== ea || o_awlen !== el) begin
                            n_err++;
                            $display("FAIL %s aw: addr=%h len=%0d, required %h %0d", tag, o_awaddr, o_awlen, ea, el);
                        end
                    end
                end else begin
                    aw_wait++;
                end
            end
            bvalid = pend_b;
            bresp  = (bursts == 0) ? resp0 : 2'b00;
            if (bvalid && o_bready) begin
                pend_b = 0; bursts++; in_fill = 1;
            end
            wtog = !wtog;
            wready = wtoggle ? wtog : 1'b1;
            if (o_wvalid && wready) begin
                n_vec++;
                if (exp_w.size() == 0) begin
                    n_err++; $display("FAIL %s w_extra: wdata=%h, required no beat", tag, o_wdata);
                end else begin
                    ew = exp_w.pop_front();
                    if (o_wdata !== ew) begin
                        n_err++; $display("FAIL %s wdata: got %h, required %h", tag, o_wdata, ew);
                    end
                end
                n_vec++;
                if (o_wlast !== (beat == cur_len)) begin
                    n_err++; $display("FAIL %s wlast: beat %0d wlast=%b, required %b", tag, beat, o_wlast, beat == cur_len);
                end
                written++;
                if (beat == cur_len) begin pend_b = 1; beat = 0; end
                else beat++;
            end
            if (stop_at > 0 && sent == stop_at && paused < pause) begin
                s_valid = 1'b0; paused++;
            end else begin
                s_valid = 1'b1; s_data = cur;
            end
            if (s_valid && o_ready) begin
                exp_w.push_back(cur); sent++; cur = {$urandom, $urandom};
            end
            if (o_done) begin
                fin = 1;
                n_vec++;
                if (o_error !== exp_err) begin
                    n_err++; $display("FAIL %s error_at_done: error=%b, required %b", tag, o_error, exp_err);
                end
            end
            cyc++;
            @(negedge clk);
        end
        idle_inputs();
        if (!fin) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout: no done after %0d cycles, required done", tag, cyc);
            rst = 1'b1; @(negedge clk); rst = 1'b0;
            return;
        end
        n_vec++;
        if ({o_busy, o_done, o_error} !== {2'b00, exp_err}) begin
            n_err++; $display("FAIL %s after_done: busy/done/error=%b, required 00%b", tag, {o_busy, o_done, o_error}, exp_err);
        end
        n_vec++;
        if (sent != n || written != n) begin
            n_err++; $display("FAIL %s beat_count: accepted=%0d written=%0d, required %0d", tag, sent, written, n);
        end
        n_vec++;
        if (exp_addr.size() != 0 || exp_w.size() != 0) begin
            n_err++; $display("FAIL %s leftover: bursts=%0d beats=%0d, required 0 0", tag, exp_addr.size(), exp_w.size());
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        sel = 2'd0;
        n_vec++;
        if ({o_awvalid, o_wvalid, o_wlast, o_bready, o_ready, o_busy, o_done, o_error} !== 8'h00) begin
            n_err++; $display("FAIL reset_ctl: got %b, required 00000000",
                              {o_awvalid, o_wvalid, o_wlast, o_bready, o_ready, o_busy, o_done, o_error});
        end
        n_vec++;
        if ({o_awaddr, o_awlen} !== 36'h0) begin
            n_err++; $display("FAIL reset_aw: addr=%h len=%h, required 0 0", o_awaddr, o_awlen);
        end
        n_vec++;
        if ({u[0].bus.m_axi_acp_awid, u[0].bus.m_axi_acp_awsize, u[0].bus.m_axi_acp_awburst,
             u[0].bus.m_axi_acp_awlock, u[0].bus.m_axi_acp_awcache, u[0].bus.m_axi_acp_awprot,
             u[0].bus.m_axi_acp_awqos, u[0].bus.m_axi_acp_awuser, u[0].bus.m_axi_acp_wid,
             u[0].bus.m_axi_acp_wstrb}
            !== {3'b100, 3'b011, 2'b01, 2'b00, 4'b0001, 3'b010, 4'h0, 5'h00, 3'b100, 8'hFF}) begin
            n_err++; $display("FAIL constants: awid=%b awsize=%b awburst=%b awcache=%b awprot=%b wstrb=%h",
                              u[0].bus.m_axi_acp_awid, u[0].bus.m_axi_acp_awsize, u[0].bus.m_axi_acp_awburst,
                              u[0].bus.m_axi_acp_awcache, u[0].bus.m_axi_acp_awprot, u[0].bus.m_axi_acp_wstrb);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_two_full_bursts();
        run_xfer(2'd0, 32'h1000_0000, 32, 0, 1'b0, 0, 0, 2'b00, 1'b0, "two_bursts");
    endtask

    task automatic test_short_burst();
        run_xfer(2'd1, 32'h1000_0044, 20, 0, 1'b0, 0, 0, 2'b00, 1'b0, "short_burst");
    endtask

    task automatic test_backpressure();
        run_xfer(2'd0, 32'h1000_1000, 32, 5, 1'b1, 0, 0, 2'b00, 1'b0, "backpressure");
    endtask

    task automatic test_slow_source();
        run_xfer(2'd0, 32'h1000_2000, 32, 0, 1'b0, 10, 30, 2'b00, 1'b0, "slow_source");
    endtask

    task automatic test_full_fifo();
        int acc;
        acc = 0;
        idle_inputs();
        sel = 2'd2;
        @(negedge clk); dst = 32'h3000_0000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            s_valid = 1'b1; s_data = 64'(c);
            awready = o_awvalid;
            if (o_ready) acc++;
            @(negedge clk);
        end
        s_valid = 1'b0; awready = 1'b0;
        n_vec++;
        if (acc != 32) begin
            n_err++; $display("FAIL full_fifo_count: accepted=%0d, required 32", acc);
        end
        n_vec++;
        if ({o_ready, o_wvalid} !== 2'b01) begin
            n_err++; $display("FAIL full_fifo_ready: s2mm_ready/wvalid=%b, required 01", {o_ready, o_wvalid});
        end
    endtask

    task automatic test_reset_mid_burst();
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({o_awvalid, o_wvalid, o_bready, o_busy, o_ready} !== 5'b00000) begin
            n_err++; $display("FAIL mid_reset: awvalid/wvalid/bready/busy/ready=%b, required 00000",
                              {o_awvalid, o_wvalid, o_bready, o_busy, o_ready});
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        run_xfer(2'd2, 32'h2000_0100, 64, 0, 1'b0, 0, 0, 2'b00, 1'b0, "after_reset");
    endtask

    task automatic test_error();
        run_xfer(2'd0, 32'h1000_3000, 32, 0, 1'b0, 0, 0, 2'b10, 1'b1, "error_resp");
        run_xfer(2'd0, 32'h1000_4000, 32, 0, 1'b0, 0, 0, 2'b00, 1'b0, "error_cleared");
    endtask

    task automatic test_addr_wrap();
        run_xfer(2'd0, 32'hFFFF_FF80, 32, 0, 1'b0, 0, 0, 2'b00, 1'b0, "addr_wrap");
    endtask

    initial begin
        test_reset();
        test_two_full_bursts();
        test_short_burst();
        test_backpressure();
        test_slow_source();
        test_full_fifo();
        test_reset_mid_burst();
        test_error();
        test_addr_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
